// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch FIFO between the fetch unit and the decoder.
// Holds DEPTH {instruction, pc} pairs; flush discards everything (redirect).
// Optional same-cycle bypass of an empty queue: define FETCH_QUEUE_BYPASS_EN.
// Without the macro, an entry pushed at one edge is visible the cycle after.

module fetch_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [31:0]              in_instruction,
   input  logic [31:0]              in_pc,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instruction,
   output logic [31:0]              out_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned DW = 32;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   // Stored payload: one fetched word and its byte address.
   typedef struct packed {
      logic [DW-1:0] instruction;
      logic [DW-1:0] pc;
   } fq_entry_t;

   // Reject configurations where pointer wrap would not be a plain modulo.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fetch_queue: DEPTH must be a power of two and at least 2");
   end

   fq_entry_t         mem_q [DEPTH];

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q,  count_d;

   logic              empty_c;
   logic              full_c;
   logic              blocked_c;
   logic              stored_valid_c;
   logic              bypass_c;
   logic              push_c;
   logic              write_c;
   logic              read_c;

   // Occupancy decode; reset and flush both block every handshake.
   always_comb begin
      empty_c        = (count_q == '0);
      full_c         = (count_q == FULL_C);
      blocked_c      = reset | flush;
      stored_valid_c = !empty_c && !blocked_c;
   end

`ifdef FETCH_QUEUE_BYPASS_EN
   // Empty queue forwards the incoming word straight to the decoder.
   always_comb begin
      bypass_c = empty_c && in_valid && !blocked_c;
   end
`else
   // No forwarding path: outputs depend on stored state only.
   always_comb begin
      bypass_c = 1'b0;
   end
`endif

   // Handshakes; in_ready depends only on state, reset and flush.
   always_comb begin
      in_ready  = !full_c && !blocked_c;
      out_valid = stored_valid_c | bypass_c;
      push_c    = in_valid && in_ready;
      // A forwarded word that the decoder takes this cycle is never stored.
      write_c   = push_c && !(bypass_c && out_ready);
      read_c    = stored_valid_c && out_ready;
   end

   // Head data mux; zero whenever nothing is presented.
   always_comb begin
      out_instruction = '0;
      out_pc          = '0;
      if (bypass_c) begin
         out_instruction = in_instruction;
         out_pc          = in_pc;
      end else if (stored_valid_c) begin
         out_instruction = mem_q[rd_ptr_q].instruction;
         out_pc          = mem_q[rd_ptr_q].pc;
      end
   end

   // Pointer and occupancy next state; flush empties the queue on the next edge.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (write_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (read_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({write_c, read_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are not reset, validity lives in count_q.
   always_ff @(posedge clk) begin
      if (write_c) begin
         mem_q[wr_ptr_q] <= '{instruction: in_instruction, pc: in_pc};
      end
   end

   // Occupancy output.
   always_comb begin
      count = count_q;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a queue-based reference model.
// Build with +define+FETCH_QUEUE_BYPASS_EN to exercise the bypass configuration.

module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic [31:0]   in_instruction;
   logic [31:0]   in_pc;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instruction;
   logic [31:0]   out_pc;
   logic [CW-1:0] count;

   int            n_checks = 0;
   int            n_fail   = 0;
   bit            chk_en   = 1'b0;

   logic [63:0]   mq [$];

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_instruction  (in_instruction),
      .in_pc           (in_pc),
      .in_ready        (in_ready),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instruction (out_instruction),
      .out_pc          (out_pc),
      .count           (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   // Expected outputs for the current inputs, derived from the model queue.
   function automatic bit m_bypass();
`ifdef FETCH_QUEUE_BYPASS_EN
      return (mq.size() == 0) && in_valid && !flush && !reset;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_in_ready();
      return !reset && !flush && (mq.size() < DEPTH);
   endfunction

   function automatic bit m_out_valid();
      return (!reset && !flush && mq.size() != 0) || m_bypass();
   endfunction

   function automatic logic [63:0] m_head();
      if (!m_out_valid()) return 64'h0;
      if (m_bypass())     return {in_instruction, in_pc};
      return mq[0];
   endfunction

   // Reference model update at each edge.
   always @(posedge clk) begin
      bit push, pop, byp;
      if (reset || flush) begin
         mq.delete();
      end else begin
         byp  = m_bypass();
         push = in_valid && m_in_ready();
         pop  = m_out_valid() && out_ready;
         if (!(byp && pop)) begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back({in_instruction, in_pc});
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [63:0] h;
      if (chk_en) begin
         h = m_head();
         check("in_ready",        64'(in_ready),        64'(m_in_ready()));
         check("out_valid",       64'(out_valid),       64'(m_out_valid()));
         check("out_instruction", 64'(out_instruction), 64'(h[63:32]));
         check("out_pc",          64'(out_pc),          64'(h[31:0]));
         check("count",           64'(count),           64'(mq.size()));
      end
   end

   task automatic drive(input logic r, input logic f, input logic iv,
                        input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
      @(posedge clk);
      #1;
      reset          = r;
      flush          = f;
      in_valid       = iv;
      in_instruction = ins;
      in_pc          = pc;
      out_ready      = ordy;
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ordy);
   endtask

   logic [31:0] instr_tab [5];

   initial begin
      instr_tab[0] = 32'hCA0F3355;
      instr_tab[1] = 32'h00330FFF;
      instr_tab[2] = 32'h20040008;
      instr_tab[3] = 32'h00000001;
      instr_tab[4] = 32'h00000002;

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
      in_instruction = '0; in_pc = '0; out_ready = 1'b0;

      // Reset for two cycles, then idle.
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk_en = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      idle(1'b0);
      check("lit_reset_count", 64'(count), 64'd0);
      check("lit_reset_in_ready", 64'(in_ready), 64'd1);
      check("lit_reset_out_valid", 64'(out_valid), 64'd0);
      check("lit_reset_out_instr", 64'(out_instruction), 64'h0);

      // Fill to DEPTH with the decoder stalled; fifth word is held.
      for (int i = 0; i < 4; i++)
         drive(1'b0, 1'b0, 1'b1, instr_tab[i], 32'(4 * i), 1'b0);
      drive(1'b0, 1'b0, 1'b1, instr_tab[4], 32'd16, 1'b0);
      check("lit_full_count", 64'(count), 64'd4);
      check("lit_full_in_ready", 64'(in_ready), 64'd0);
      // Full with a pop in the same cycle still refuses the push.
      drive(1'b0, 1'b0, 1'b1, instr_tab[4], 32'd16, 1'b1);
      check("lit_pop0_pc", 64'(out_pc), 64'd0);
      check("lit_pop0_instr", 64'(out_instruction), 64'hCA0F3355);
      check("lit_full_pop_in_ready", 64'(in_ready), 64'd0);
      drive(1'b0, 1'b0, 1'b1, instr_tab[4], 32'd16, 1'b1);
      check("lit_pop1_pc", 64'(out_pc), 64'd4);
      check("lit_fifth_accept", 64'(in_ready), 64'd1);
      for (int i = 2; i < 5; i++) begin
         idle(1'b1);
         check("lit_pop_pc", 64'(out_pc), 64'(4 * i));
         check("lit_pop_instr", 64'(out_instruction), 64'(instr_tab[i]));
      end
      idle(1'b0);
      check("lit_drained_count", 64'(count), 64'd0);
      check("lit_drained_out_valid", 64'(out_valid), 64'd0);

      // Steady push and pop from count = 2; pointers wrap.
      drive(1'b0, 1'b0, 1'b1, 32'hA0000000, 32'h100, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'hA0000001, 32'h104, 1'b0);
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b0, 1'b1, 32'hA0000002 + 32'(k), 32'h108 + 32'(4 * k), 1'b1);
         check("lit_stream_count", 64'(count), 64'd2);
         check("lit_stream_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * k)));
      end
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);
      check("lit_stream_drained", 64'(count), 64'd0);

      // Flush a 3-entry queue with in_valid high.
      for (int i = 0; i < 3; i++)
         drive(1'b0, 1'b0, 1'b1, 32'hB0000000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0);
      drive(1'b0, 1'b1, 1'b1, 32'hB0000003, 32'h20C, 1'b1);
      check("lit_flush_in_ready", 64'(in_ready), 64'd0);
      check("lit_flush_out_valid", 64'(out_valid), 64'd0);
      drive(1'b0, 1'b0, 1'b1, 32'h20040008, 32'h8, 1'b0);
      check("lit_post_flush_count", 64'(count), 64'd0);
      idle(1'b1);
      check("lit_post_flush_count1", 64'(count), 64'd1);
      check("lit_post_flush_pc", 64'(out_pc), 64'h8);

      // Multi-cycle flush, then a push in the first cycle afterwards.
      drive(1'b0, 1'b0, 1'b1, 32'hC0000000, 32'h400, 1'b0);
      for (int i = 0; i < 3; i++)
         drive(1'b0, 1'b1, 1'b1, 32'hC0000001, 32'h404, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'hC0000002, 32'h408, 1'b0);
      check("lit_resume_in_ready", 64'(in_ready), 64'd1);
      idle(1'b1);
      check("lit_resume_pc", 64'(out_pc), 64'h408);
      idle(1'b0);

      // Push into an empty queue with the decoder ready.
      drive(1'b0, 1'b0, 1'b1, 32'h20040008, 32'h300, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
      check("lit_byp_out_valid", 64'(out_valid), 64'd1);
      check("lit_byp_instr", 64'(out_instruction), 64'h20040008);
      idle(1'b1);
      check("lit_byp_count", 64'(count), 64'd0);
      check("lit_byp_out_valid_after", 64'(out_valid), 64'd0);
`else
      check("lit_lat_out_valid", 64'(out_valid), 64'd0);
      idle(1'b1);
      check("lit_lat_out_valid_next", 64'(out_valid), 64'd1);
      check("lit_lat_instr", 64'(out_instruction), 64'h20040008);
      check("lit_lat_count", 64'(count), 64'd1);
      idle(1'b0);
      check("lit_lat_drained", 64'(count), 64'd0);
`endif

      // Reset mid-stream with two entries queued.
      drive(1'b0, 1'b0, 1'b1, 32'hD0000000, 32'h500, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'hD0000001, 32'h504, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 32'hD0000002, 32'h508, 1'b1);
      check("lit_rst_in_ready", 64'(in_ready), 64'd0);
      check("lit_rst_out_valid", 64'(out_valid), 64'd0);
      drive(1'b1, 1'b0, 1'b1, 32'hD0000002, 32'h508, 1'b1);
      idle(1'b0);
      check("lit_rst_count", 64'(count), 64'd0);
      check("lit_rst_in_ready_after", 64'(in_ready), 64'd1);
      check("lit_rst_out_valid_after", 64'(out_valid), 64'd0);
      idle(1'b0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
